// File: rtl/alu_issue_arbiter.sv
// Purpose: round-robin share of two integer ALU lanes between NREQ requesters; tag returns each result to its issuer.
// Latency: handshake at edge N, ALU operands registered at N, response visible for one cycle after edge N+1.
// Backpressure: req_ready grants up to two requesters per cycle; responses cannot be stalled by the requester.
// Optional build macro: ALU_ISSUE_ARB_STATS_EN enables the saturating issue_count counter (tied to 0 otherwise).
module alu_issue_arbiter #(
    parameter int              NREQ   = 4,
    parameter int              DW     = 64,
    parameter int              OPW    = 8,
    parameter logic [OPW-1:0]  NOP_OP = 8'h80
) (
    input  logic                c,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*DW-1:0]  req_a,
    input  logic [NREQ*DW-1:0]  req_b,
    input  logic [NREQ*OPW-1:0] req_op,
    output logic [DW-1:0]       alu_a0,
    output logic [DW-1:0]       alu_b0,
    output logic [OPW-1:0]      alu_op0,
    output logic [DW-1:0]       alu_a1,
    output logic [DW-1:0]       alu_b1,
    output logic [OPW-1:0]      alu_op1,
    input  logic [DW-1:0]       alu_out0,
    input  logic [DW-1:0]       alu_out1,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [NREQ*DW-1:0]  rsp_data,
    output logic [31:0]         issue_count
);

    localparam int              PW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW:0]     NREQ_W = (PW+1)'(NREQ);
    localparam logic [PW-1:0]   LAST   = PW'(NREQ - 1);

    logic [PW-1:0] rr_ptr;
    logic [PW:0]   scan;
    logic          g0_vld, g1_vld;
    logic [PW-1:0] g0_idx, g1_idx, last_idx;

    logic          lane0_vld, lane1_vld;
    logic [PW-1:0] lane0_tag, lane1_tag;
    logic          rsp0_vld, rsp1_vld;
    logic [PW-1:0] rsp0_tag, rsp1_tag;

    // Scan from rr_ptr with wrap; first valid requester takes lane 0, second takes lane 1.
    always_comb begin
        g0_vld = 1'b0;
        g1_vld = 1'b0;
        g0_idx = '0;
        g1_idx = '0;
        scan   = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan = {1'b0, rr_ptr} + (PW+1)'(k);
            if (scan >= NREQ_W) begin
                scan = scan - NREQ_W;
            end
            if (!rst && req_valid[scan[PW-1:0]]) begin
                if (!g0_vld) begin
                    g0_vld = 1'b1;
                    g0_idx = scan[PW-1:0];
                end else if (!g1_vld) begin
                    g1_vld = 1'b1;
                    g1_idx = scan[PW-1:0];
                end
            end
        end
    end

    // Grants are a subset of req_valid, so a grant is a completed handshake.
    always_comb begin
        req_ready = '0;
        if (g0_vld) req_ready[g0_idx] = 1'b1;
        if (g1_vld) req_ready[g1_idx] = 1'b1;
    end

    assign last_idx = g1_vld ? g1_idx : g0_idx;

    // Pointer advance and issue stage: register granted operands into their lane, idle lanes get NOP_OP.
    always_ff @(posedge c) begin
        if (rst) begin
            rr_ptr    <= '0;
            lane0_vld <= 1'b0;
            lane1_vld <= 1'b0;
            lane0_tag <= '0;
            lane1_tag <= '0;
            alu_a0    <= '0;
            alu_b0    <= '0;
            alu_op0   <= NOP_OP;
            alu_a1    <= '0;
            alu_b1    <= '0;
            alu_op1   <= NOP_OP;
        end else begin
            if (g0_vld) begin
                rr_ptr <= (last_idx == LAST) ? '0 : last_idx + PW'(1);
            end
            lane0_vld <= g0_vld;
            lane1_vld <= g1_vld;
            if (g0_vld) begin
                lane0_tag <= g0_idx;
                alu_a0    <= req_a[g0_idx*DW +: DW];
                alu_b0    <= req_b[g0_idx*DW +: DW];
                alu_op0   <= req_op[g0_idx*OPW +: OPW];
            end else begin
                alu_op0   <= NOP_OP;
            end
            if (g1_vld) begin
                lane1_tag <= g1_idx;
                alu_a1    <= req_a[g1_idx*DW +: DW];
                alu_b1    <= req_b[g1_idx*DW +: DW];
                alu_op1   <= req_op[g1_idx*OPW +: OPW];
            end else begin
                alu_op1   <= NOP_OP;
            end
        end
    end

    // Result stage: tags follow the ALU's own output register by one edge.
    always_ff @(posedge c) begin
        if (rst) begin
            rsp0_vld <= 1'b0;
            rsp1_vld <= 1'b0;
            rsp0_tag <= '0;
            rsp1_tag <= '0;
        end else begin
            rsp0_vld <= lane0_vld;
            rsp1_vld <= lane1_vld;
            rsp0_tag <= lane0_tag;
            rsp1_tag <= lane1_tag;
        end
    end

    // Route each valid lane result to the requester that issued it; the two tags never collide.
    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        if (rsp0_vld) begin
            rsp_valid[rsp0_tag]          = 1'b1;
            rsp_data[rsp0_tag*DW +: DW]  = alu_out0;
        end
        if (rsp1_vld) begin
            rsp_valid[rsp1_tag]          = 1'b1;
            rsp_data[rsp1_tag*DW +: DW]  = alu_out1;
        end
    end

`ifdef ALU_ISSUE_ARB_STATS_EN
    logic [31:0] cnt_q;
    logic [32:0] cnt_sum;

    assign cnt_sum = {1'b0, cnt_q} + 33'(g0_vld) + 33'(g1_vld);

    // Saturating count of accepted requests.
    always_ff @(posedge c) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
        end
    end

    assign issue_count = cnt_q;
`else
    assign issue_count = '0;
`endif

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Directed bench for alu_issue_arbiter with an adder standing in for the two ALU instances.
module tb_alu_issue_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 64;
    localparam int OPW  = 8;

    logic                c = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*DW-1:0]  req_a = '0;
    logic [NREQ*DW-1:0]  req_b = '0;
    logic [NREQ*OPW-1:0] req_op = '0;
    logic [DW-1:0]       alu_a0, alu_b0, alu_a1, alu_b1;
    logic [OPW-1:0]      alu_op0, alu_op1;
    logic [DW-1:0]       alu_out0, alu_out1;
    logic [NREQ-1:0]     rsp_valid;
    logic [NREQ*DW-1:0]  rsp_data;
    logic [31:0]         issue_count;

    int checks = 0;
    int errors = 0;

    alu_issue_arbiter #(.NREQ(NREQ), .DW(DW), .OPW(OPW), .NOP_OP(8'h80)) dut (
        .c(c), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .alu_a0(alu_a0), .alu_b0(alu_b0), .alu_op0(alu_op0),
        .alu_a1(alu_a1), .alu_b1(alu_b1), .alu_op1(alu_op1),
        .alu_out0(alu_out0), .alu_out1(alu_out1),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .issue_count(issue_count)
    );

    always #5 c = ~c;

    // Registered adder ALU: result appears one edge after operands.
    always @(posedge c) begin
        alu_out0 <= alu_a0 + alu_b0;
        alu_out1 <= alu_a1 + alu_b1;
    end

    function automatic logic [DW-1:0] slot(input logic [NREQ*DW-1:0] v, input int i);
        return v[i*DW +: DW];
    endfunction

    task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [OPW-1:0] op);
        req_a[i*DW +: DW]    = a;
        req_b[i*DW +: DW]    = b;
        req_op[i*OPW +: OPW] = op;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        @(negedge c);
        @(negedge c);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 4'b1111;
        @(negedge c);
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++; $display("FAIL reset_ready got=%b exp=0000", req_ready);
        end
        @(negedge c);
        checks++;
        if (alu_op0 !== 8'h80 || alu_op1 !== 8'h80) begin
            errors++; $display("FAIL reset_ops got=%h/%h exp=80/80", alu_op0, alu_op1);
        end
        checks++;
        if (rsp_valid !== 4'b0000 || alu_a0 !== 64'd0 || issue_count !== 32'd0) begin
            errors++; $display("FAIL reset_state rsp_valid=%b alu_a0=%0d issue_count=%0d", rsp_valid, alu_a0, issue_count);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0011) begin
            errors++; $display("FAIL reset_first_grant got=%b exp=0011", req_ready);
        end
        req_valid = '0;
    endtask

    task automatic test_single_add();
        do_reset();
        set_req(2, 64'd5, 64'd7, 8'd32);
        req_valid = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++; $display("FAIL single_ready got=%b exp=0100", req_ready);
        end
        @(negedge c);
        req_valid = '0;
        #1;
        checks++;
        if (alu_op0 !== 8'd32 || alu_a0 !== 64'd5 || alu_b0 !== 64'd7 || alu_op1 !== 8'h80) begin
            errors++; $display("FAIL single_issue op0=%0d a0=%0d b0=%0d op1=%h exp 32/5/7/80", alu_op0, alu_a0, alu_b0, alu_op1);
        end
        @(negedge c);
        checks++;
        if (rsp_valid !== 4'b0100 || slot(rsp_data, 2) !== 64'd12 || slot(rsp_data, 0) !== 64'd0) begin
            errors++; $display("FAIL single_rsp valid=%b data2=%0d data0=%0d exp 0100/12/0", rsp_valid, slot(rsp_data, 2), slot(rsp_data, 0));
        end
        checks++;
        if (alu_op0 !== 8'h80) begin
            errors++; $display("FAIL single_idle_op got=%h exp=80", alu_op0);
        end
        @(negedge c);
        checks++;
        if (rsp_valid !== 4'b0000) begin
            errors++; $display("FAIL single_pulse got=%b exp=0000", rsp_valid);
        end
    endtask

    task automatic test_fairness();
        int cnt[NREQ];
        logic [NREQ-1:0] exp_rdy;
        logic [NREQ-1:0] exp_rsp;
        do_reset();
        for (int i = 0; i < NREQ; i++) cnt[i] = 0;
        for (int t = 0; t < 8; t++) begin
            if (t < 6) begin
                req_valid = 4'b1111;
                for (int i = 0; i < NREQ; i++) set_req(i, 64'(i*16 + t), 64'd1, 8'd32);
            end else begin
                req_valid = '0;
            end
            #1;
            if (t < 6) begin
                exp_rdy = (t % 2 == 0) ? 4'b0011 : 4'b1100;
                checks++;
                if (req_ready !== exp_rdy) begin
                    errors++; $display("FAIL fair_grant t=%0d got=%b exp=%b", t, req_ready, exp_rdy);
                end
            end
            if (t >= 2) begin
                exp_rsp = ((t - 2) % 2 == 0) ? 4'b0011 : 4'b1100;
                checks++;
                if (rsp_valid !== exp_rsp) begin
                    errors++; $display("FAIL fair_rsp_valid t=%0d got=%b exp=%b", t, rsp_valid, exp_rsp);
                end
                for (int i = 0; i < NREQ; i++) begin
                    if (rsp_valid[i]) cnt[i]++;
                    if (exp_rsp[i]) begin
                        checks++;
                        if (slot(rsp_data, i) !== 64'(i*16 + (t - 2) + 1)) begin
                            errors++; $display("FAIL fair_rsp_data t=%0d req=%0d got=%0d exp=%0d", t, i, slot(rsp_data, i), i*16 + (t - 2) + 1);
                        end
                    end
                end
            end
            @(negedge c);
        end
        for (int i = 0; i < NREQ; i++) begin
            checks++;
            if (cnt[i] != 3) begin
                errors++; $display("FAIL fair_count req=%0d got=%0d exp=3", i, cnt[i]);
            end
        end
    endtask

    task automatic test_wrap_skip();
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 64'(i), 64'd0, 8'(8'h10 + i));
        req_valid = 4'b0011;
        @(negedge c);
        req_valid = 4'b1001;
        #1;
        checks++;
        if (req_ready !== 4'b1001) begin
            errors++; $display("FAIL wrap_grant got=%b exp=1001", req_ready);
        end
        @(negedge c);
        req_valid = 4'b1111;
        #1;
        checks++;
        if (alu_op0 !== 8'h13 || alu_op1 !== 8'h10) begin
            errors++; $display("FAIL wrap_lanes op0=%h op1=%h exp 13/10", alu_op0, alu_op1);
        end
        checks++;
        if (req_ready !== 4'b0110) begin
            errors++; $display("FAIL wrap_ptr got=%b exp=0110", req_ready);
        end
        req_valid = '0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int t = 0; t < 5; t++) begin
            if (t < 3) begin
                req_valid = 4'b0010;
                set_req(1, 64'(100 + t), 64'(t), 8'd32);
            end else begin
                req_valid = '0;
            end
            #1;
            if (t < 3) begin
                checks++;
                if (req_ready !== 4'b0010) begin
                    errors++; $display("FAIL b2b_grant t=%0d got=%b exp=0010", t, req_ready);
                end
            end
            if (t >= 2) begin
                checks++;
                if (rsp_valid !== 4'b0010 || slot(rsp_data, 1) !== 64'(100 + 2*(t - 2))) begin
                    errors++; $display("FAIL b2b_rsp t=%0d valid=%b data=%0d exp 0010/%0d", t, rsp_valid, slot(rsp_data, 1), 100 + 2*(t - 2));
                end
            end
            @(negedge c);
        end
    endtask

    task automatic test_midflight_reset();
        do_reset();
        set_req(0, 64'd11, 64'd22, 8'd32);
        set_req(1, 64'd33, 64'd44, 8'd32);
        req_valid = 4'b0011;
        @(negedge c);
        rst       = 1'b1;
        req_valid = '0;
        @(negedge c);
        rst = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 4'b0000 || alu_op0 !== 8'h80) begin
            errors++; $display("FAIL midrst_rsp valid=%b op0=%h exp 0000/80", rsp_valid, alu_op0);
        end
        @(negedge c);
        checks++;
        if (rsp_valid !== 4'b0000) begin
            errors++; $display("FAIL midrst_late got=%b exp=0000", rsp_valid);
        end
        req_valid = 4'b1111;
        #1;
        checks++;
        if (req_ready !== 4'b0011) begin
            errors++; $display("FAIL midrst_ptr got=%b exp=0011", req_ready);
        end
        req_valid = '0;
    endtask

    task automatic test_stats();
        logic [31:0] exp_cnt;
`ifdef ALU_ISSUE_ARB_STATS_EN
        exp_cnt = 32'd20;
`else
        exp_cnt = 32'd0;
`endif
        do_reset();
        req_valid = 4'b1111;
        repeat (10) @(negedge c);
        req_valid = '0;
        #1;
        checks++;
        if (issue_count !== exp_cnt) begin
            errors++; $display("FAIL stats_count got=%0d exp=%0d", issue_count, exp_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_fairness();
        test_wrap_skip();
        test_back_to_back();
        test_midflight_reset();
        test_stats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
